vx_acc_unit: RTL and testbench

VX_ACC_UNIT -- requirements
Module: VX_acc_unit

---
 rtl/vx_acc_unit.sv | 202 ++++++++++++++++++++
 tb/tb_vx_acc_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_acc_unit.sv
// -----------------------------------------------------------------------------
// vx_acc_unit
//
// Command-driven 32-bit accumulator with an offload path to an external
// accelerator. Commands are queued in a small FIFO and executed one per cycle
// by a three-state controller (IDLE / REQ / WAIT). An OFFLOAD command hands
// the current accumulator to the accelerator over a valid/ready request
// channel and replaces the accumulator with the accelerator's response.
//
// Command word: op = [31:30], imm = [29:0]
//   00 SET      ACC <= {2'b00, imm}
//   01 ADD      ACC <= ACC + sign_extend(imm)   (wraps modulo 2^32)
//   10 OFFLOAD  req_data <= ACC, then request/response handshake
//   11 CLR      ACC <= 0
//
// Ports
//   clk            sole clock, rising edge
//   reset          asynchronous, active-low reset
//   acc_write_en   command write strobe (one command per asserted cycle)
//   acc_write_out  command word
//   acc_read_in    current accumulator value (registered)
//   req_valid      offload request valid (only in REQ)
//   req_data       offload operand, stable while req_valid=1
//   req_ready      accelerator accepts the request
//   rsp_valid      accelerator result valid
//   rsp_data       accelerator result
//   rsp_ready      unit accepts the result (only in WAIT)
//   busy           FIFO non-empty or controller not idle
//   overflow       sticky: a command was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module vx_acc_unit #(
  parameter int CMD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        acc_write_en,
  input  logic [31:0] acc_write_out,
  output logic [31:0] acc_read_in,
  output logic        req_valid,
  output logic [31:0] req_data,
  input  logic        req_ready,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  output logic        rsp_ready,
  output logic        busy,
  output logic        overflow
);

  localparam int DATA_W = 32;
  localparam int IMM_W  = 30;
  localparam int PTR_W  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(CMD_DEPTH);

  typedef enum logic [1:0] {
    OP_SET     = 2'b00,
    OP_ADD     = 2'b01,
    OP_OFFLOAD = 2'b10,
    OP_CLR     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } state_e;

  // Immediate is a 30-bit two's complement value for ADD.
  function automatic logic signed [DATA_W-1:0] sext_imm(
    input logic [IMM_W-1:0] imm
  );
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  // Plain modulo-2^32 add: overflow wraps silently, no saturation.
  function automatic logic signed [DATA_W-1:0] wrap_add(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return a + b;
  endfunction

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [CMD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head_cmd;

  state_e                    state;
  logic signed [DATA_W-1:0]  acc;

  // Pops only happen in IDLE, and only on entries already registered in the
  // count, so a command written this cycle can never execute this cycle.
  assign pop      = (state == ST_IDLE) && (count != '0);
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push     = acc_write_en && ((count < DEPTH_C) || pop);
  assign head_cmd = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define validity.
  // On a simultaneous push/pop at full, wr_ptr == rd_ptr: the head is read
  // combinationally before the edge overwrites that slot.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= acc_write_out;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (acc_write_en && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Controller and accumulator
  // ---------------------------------------------------------------------------
  op_e              head_op;
  logic [IMM_W-1:0] head_imm;

  assign head_op  = op_e'(head_cmd[31:30]);
  assign head_imm = head_cmd[IMM_W-1:0];

  // Accumulator and offload operand are architecturally visible and must read
  // zero out of reset, so they sit on the reset alongside the control state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      acc       <= '0;
      req_data  <= '0;
      req_valid <= 1'b0;
      rsp_ready <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            case (head_op)
              OP_SET:  acc <= {2'b00, head_imm};
              OP_ADD:  acc <= wrap_add(acc, sext_imm(head_imm));
              OP_CLR:  acc <= '0;
              OP_OFFLOAD: begin
                req_data  <= acc;
                req_valid <= 1'b1;
                state     <= ST_REQ;
              end
              default: acc <= acc;
            endcase
          end
        end

        ST_REQ: begin
          // req_data is untouched here, so it stays stable until accepted.
          if (req_ready) begin
            req_valid <= 1'b0;
            rsp_ready <= 1'b1;
            state     <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (rsp_valid) begin
            acc       <= rsp_data;
            rsp_ready <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          req_valid <= 1'b0;
          rsp_ready <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign acc_read_in = acc;
  assign busy        = (count != '0) || (state != ST_IDLE);

endmodule

// File: tb/tb_vx_acc_unit.sv
module tb_vx_acc_unit;

  logic        clk;
  logic        reset;
  logic        acc_write_en;
  logic [31:0] acc_write_out;
  logic [31:0] acc_read_in;
  logic        req_valid;
  logic [31:0] req_data;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_ready;
  logic        busy;
  logic        overflow;

  int checks;
  int failures;

  vx_acc_unit #(.CMD_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .acc_write_en (acc_write_en),
    .acc_write_out(acc_write_out),
    .acc_read_in  (acc_read_in),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_ready    (rsp_ready),
    .busy         (busy),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] cmd;
    logic [31:0] exp_acc;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // One clock: drive a command (or none), take the edge, settle 1 time unit.
  task automatic step(input logic wr, input logic [31:0] cmd);
    acc_write_en  = wr;
    acc_write_out = cmd;
    @(posedge clk);
    #1;
    acc_write_en  = 1'b0;
    acc_write_out = 32'h0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_acc"},       acc_read_in,   32'h0);
    chk({tag, "_req_valid"}, 32'(req_valid), 32'h0);
    chk({tag, "_req_data"},  req_data,      32'h0);
    chk({tag, "_rsp_ready"}, 32'(rsp_ready), 32'h0);
    chk({tag, "_busy"},      32'(busy),      32'h0);
    chk({tag, "_overflow"},  32'(overflow),  32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b0;
    acc_write_en  = 1'b0;
    acc_write_out = 32'h0;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_data      = 32'h0;

    // Arithmetic sequence; each row = one cycle, expectations after its edge.
    vecs[0]  = '{1'b1, 32'h0000_0005, 32'h0000_0000, 1'b1}; // SET 5
    vecs[1]  = '{1'b1, 32'h7FFF_FFFF, 32'h0000_0005, 1'b1}; // ADD -1
    vecs[2]  = '{1'b0, 32'h0000_0000, 32'h0000_0004, 1'b0};
    vecs[3]  = '{1'b1, 32'h3FFF_FFFF, 32'h0000_0004, 1'b1}; // SET 3FFFFFFF
    vecs[4]  = '{1'b1, 32'h4000_0001, 32'h3FFF_FFFF, 1'b1}; // ADD 1
    vecs[5]  = '{1'b1, 32'h4000_0001, 32'h4000_0000, 1'b1}; // ADD 1
    vecs[6]  = '{1'b1, 32'h0000_0000, 32'h4000_0001, 1'b1}; // SET 0
    vecs[7]  = '{1'b1, 32'h6000_0000, 32'h0000_0000, 1'b1}; // ADD 20000000 (neg)
    vecs[8]  = '{1'b0, 32'h0000_0000, 32'hE000_0000, 1'b0};
    vecs[9]  = '{1'b1, 32'hC000_0000, 32'hE000_0000, 1'b1}; // CLR
    vecs[10] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    reset = 1'b1;

    // First command lands on the first edge after release.
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].wr, vecs[i].cmd);
      chk($sformatf("row%0d_acc", i),       acc_read_in,    vecs[i].exp_acc);
      chk($sformatf("row%0d_busy", i),      32'(busy),      32'(vecs[i].exp_busy));
      chk($sformatf("row%0d_req_valid", i), 32'(req_valid), 32'h0);
      chk($sformatf("row%0d_rsp_ready", i), 32'(rsp_ready), 32'h0);
      chk($sformatf("row%0d_overflow", i),  32'(overflow),  32'h0);
    end

    // Offload with back-pressure, stray response during REQ ignored.
    step(1'b1, 32'h0000_0007);
    step(1'b1, 32'h8000_0000);
    chk("off_set7_acc", acc_read_in, 32'h7);
    step(1'b0, 32'h0);
    chk("off_hold0_valid", 32'(req_valid), 32'h1);
    chk("off_hold0_data",  req_data,       32'h7);
    rsp_valid = 1'b1;
    rsp_data  = 32'h0000_0BAD;
    step(1'b0, 32'h0);
    rsp_valid = 1'b0;
    chk("off_hold1_valid", 32'(req_valid), 32'h1);
    chk("off_hold1_data",  req_data,       32'h7);
    chk("off_hold1_acc",   acc_read_in,    32'h7);
    chk("off_hold1_rspr",  32'(rsp_ready), 32'h0);
    step(1'b0, 32'h0);
    chk("off_hold2_valid", 32'(req_valid), 32'h1);
    chk("off_hold2_data",  req_data,       32'h7);
    chk("off_hold2_busy",  32'(busy),      32'h1);
    req_ready = 1'b1;
    step(1'b0, 32'h0);
    req_ready = 1'b0;
    chk("off_wait_valid", 32'(req_valid), 32'h0);
    chk("off_wait_rspr",  32'(rsp_ready), 32'h1);
    chk("off_wait_busy",  32'(busy),      32'h1);
    rsp_valid = 1'b1;
    rsp_data  = 32'h0000_1234;
    step(1'b0, 32'h0);
    rsp_valid = 1'b0;
    chk("off_rsp_acc",  acc_read_in,    32'h1234);
    chk("off_rsp_busy", 32'(busy),      32'h0);
    chk("off_rsp_rspr", 32'(rsp_ready), 32'h0);

    // Fill FIFO during WAIT, fifth write dropped, queue drains in order.
    step(1'b1, 32'h8000_0000);
    step(1'b0, 32'h0);
    chk("ovf_req_data", req_data, 32'h1234);
    req_ready = 1'b1;
    step(1'b0, 32'h0);
    req_ready = 1'b0;
    chk("ovf_wait_rspr", 32'(rsp_ready), 32'h1);
    step(1'b1, 32'h0000_0010);
    step(1'b1, 32'h4000_0001);
    step(1'b1, 32'h4000_0002);
    step(1'b1, 32'h4000_0003);
    chk("ovf_full_overflow", 32'(overflow), 32'h0);
    step(1'b1, 32'hC000_0000);
    chk("ovf_drop_overflow", 32'(overflow), 32'h1);
    chk("ovf_drop_acc",      acc_read_in,   32'h1234);
    rsp_valid = 1'b1;
    rsp_data  = 32'h0000_0100;
    step(1'b0, 32'h0);
    rsp_valid = 1'b0;
    chk("ovf_rsp_acc", acc_read_in, 32'h100);
    step(1'b0, 32'h0);
    chk("ovf_ex0_acc", acc_read_in, 32'h10);
    step(1'b0, 32'h0);
    chk("ovf_ex1_acc", acc_read_in, 32'h11);
    step(1'b0, 32'h0);
    chk("ovf_ex2_acc", acc_read_in, 32'h13);
    step(1'b0, 32'h0);
    chk("ovf_ex3_acc",  acc_read_in, 32'h16);
    chk("ovf_ex3_busy", 32'(busy),   32'h0);
    step(1'b0, 32'h0);
    chk("ovf_after_acc",      acc_read_in,   32'h16);
    chk("ovf_after_overflow", 32'(overflow), 32'h1);

    // Reset, then full FIFO in IDLE with a write in the popping cycle.
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst2_overflow", 32'(overflow), 32'h0);
    chk("rst2_acc",      acc_read_in,   32'h0);
    step(1'b1, 32'h8000_0000);
    step(1'b0, 32'h0);
    req_ready = 1'b1;
    step(1'b0, 32'h0);
    req_ready = 1'b0;
    step(1'b1, 32'h4000_0001);
    step(1'b1, 32'h4000_0002);
    step(1'b1, 32'h4000_0004);
    step(1'b1, 32'h4000_0008);
    rsp_valid = 1'b1;
    rsp_data  = 32'h0000_1000;
    step(1'b0, 32'h0);
    rsp_valid = 1'b0;
    chk("full_rsp_acc", acc_read_in, 32'h1000);
    step(1'b1, 32'h4000_0010);
    chk("full_pp_acc",      acc_read_in,   32'h1001);
    chk("full_pp_overflow", 32'(overflow), 32'h0);
    step(1'b0, 32'h0);
    chk("full_d1_acc", acc_read_in, 32'h1003);
    step(1'b0, 32'h0);
    chk("full_d2_acc", acc_read_in, 32'h1007);
    step(1'b0, 32'h0);
    chk("full_d3_acc",  acc_read_in, 32'h100F);
    chk("full_d3_busy", 32'(busy),   32'h1);
    step(1'b0, 32'h0);
    chk("full_d4_acc",      acc_read_in,   32'h101F);
    chk("full_d4_busy",     32'(busy),     32'h0);
    chk("full_d4_overflow", 32'(overflow), 32'h0);

    // Reset while waiting for a response; late response ignored.
    step(1'b1, 32'h8000_0000);
    step(1'b0, 32'h0);
    chk("mid_req_data", req_data, 32'h101F);
    req_ready = 1'b1;
    step(1'b0, 32'h0);
    req_ready = 1'b0;
    chk("mid_wait_rspr", 32'(rsp_ready), 32'h1);
    #1;
    reset = 1'b0;
    #1;
    chk_idle_outputs("mid_rst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    rsp_valid = 1'b1;
    rsp_data  = 32'h0000_DEAD;
    step(1'b0, 32'h0);
    rsp_valid = 1'b0;
    chk("mid_post_acc",  acc_read_in,    32'h0);
    chk("mid_post_rspr", 32'(rsp_ready), 32'h0);
    chk("mid_post_busy", 32'(busy),      32'h0);
    chk("mid_post_reqv", 32'(req_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
